dm_page_sched: RTL and testbench

- Round-robin scheduler that shares the 8-digit seven-segment display between N requesters.
- Each requester presents a 16-bit value plus a 3-bit tag. The block grants one requester at a time and holds its page for a fixed dwell time.
- Between pages it inserts a blank gap.
- Outputs are the eight 6-bit digit fields {enable, hex[3:0], dp} that feed the display driver directly.

---
 rtl/dm_pkg.sv | 23 ++
 rtl/dm_rr_arbiter.sv | 41 ++++
 rtl/dm_page_sched.sv | 193 +++++++++++++++++++
 tb/tb_dm_page_sched.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and helpers for display-sharing blocks: digit field layout,
// blank digit constant and the page scheduler state encoding.
// Latency: n/a (types and functions only). Backpressure: n/a.
package dm_pkg;

  localparam int DIGIT_W = 6;

  // Digit field as consumed by the display driver: {en, hex[3:0], dp}.
  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t BLANK_DIGIT = '0;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } state_t;

  function automatic digit_t mk_digit(input logic en, input logic [3:0] hex, input logic dp);
    return {en, hex, dp};
  endfunction

endpackage

// File: rtl/dm_rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping modulo N.
// Latency: purely combinational. Backpressure: none; pick is valid whenever any=1.
// Ports: req (N requests), ptr (search start), pick (one-hot), index (binary), any.
module dm_rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [N-1:0] pick,
  output logic [2:0]   index,
  output logic         any
);

  logic [N-1:0] upper;
  logic [N-1:0] sel;

  // Requests at or above the pointer win; if none, wrap to the lowest set bit.
  always_comb begin
    upper = '0;
    for (int i = 0; i < N; i++) begin
      upper[i] = req[i] && (i >= int'(ptr));
    end
  end

  assign sel = (|upper) ? upper : req;
  assign any = |req;

  // Walk downwards so the lowest set bit of sel is the last one written.
  always_comb begin
    pick  = '0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
        index   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/dm_page_sched.sv
// Round-robin sharing of an 8-digit display between N requesters, one page per grant.
// Latency: request sampled in IDLE -> gnt and digits valid after that edge; page lasts
//   DWELL_CYCLES, then BLANK_CYCLES of blank gap. Backpressure: requests are level-held
//   and wait while a page or gap is in progress; dropping req aborts the owner's page.
// Ports: clock, reset (async active-low), req/data/tag per requester, gnt (one-hot),
//   ack (page-complete pulse), busy, d1..d8 digit fields {en, hex[3:0], dp}.
// Optional: define DM_PREEMPT_EN to give requester 0 preemptive priority.
module dm_page_sched
  import dm_pkg::*;
#(
  parameter int N            = 3,
  parameter int DWELL_CYCLES = 100000000,
  parameter int BLANK_CYCLES = 10000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [16*N-1:0]    data,
  input  logic [3*N-1:0]     tag,
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       ack,
  output logic               busy,
  output logic [DIGIT_W-1:0] d1,
  output logic [DIGIT_W-1:0] d2,
  output logic [DIGIT_W-1:0] d3,
  output logic [DIGIT_W-1:0] d4,
  output logic [DIGIT_W-1:0] d5,
  output logic [DIGIT_W-1:0] d6,
  output logic [DIGIT_W-1:0] d7,
  output logic [DIGIT_W-1:0] d8
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);

  localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LOAD = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [2:0]    LAST_IDX   = 3'(N - 1);

  state_t         state_q, state_d;
  logic [2:0]     rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [N-1:0]   ack_q, ack_d;
  logic [2:0]     idx_q, idx_d;
  logic [15:0]    data_q, data_d;
  logic [2:0]     tag_q, tag_d;

  logic [2:0]     arb_ptr;
  logic [N-1:0]   arb_pick;
  logic [2:0]     arb_index;
  logic           arb_any;
  logic           owner_req;
  logic           preempt;
  logic [2:0]     ptr_adv;

`ifdef DM_PREEMPT_EN
  // Requester 0 always wins in IDLE and kicks any other owner off the display.
  assign arb_ptr = req[0] ? 3'd0 : rr_ptr_q;
  assign preempt = req[0] && !gnt_q[0];
`else
  assign arb_ptr = rr_ptr_q;
  assign preempt = 1'b0;
`endif

  dm_rr_arbiter #(
    .N (N)
  ) u_arb (
    .req   (req),
    .ptr   (arb_ptr),
    .pick  (arb_pick),
    .index (arb_index),
    .any   (arb_any)
  );

  // Owner's request still held; gnt_q is one-hot in SHOW so this selects req[owner].
  assign owner_req = |(req & gnt_q);
  assign ptr_adv   = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      timer_q  <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      timer_q  <= timer_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    timer_d  = timer_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    idx_d    = idx_q;
    data_d   = data_q;
    tag_d    = tag_q;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = SHOW;
          gnt_d   = arb_pick;
          idx_d   = arb_index;
          timer_d = DWELL_LOAD;
          for (int i = 0; i < N; i++) begin
            if (arb_pick[i]) begin
              data_d = data[16*i +: 16];
              tag_d  = tag[3*i +: 3];
            end
          end
        end
      end

      SHOW: begin
        if (preempt) begin
          // Preemption skips the gap and leaves the pointer alone so the
          // interrupted round-robin position is resumed afterwards.
          state_d = IDLE;
          gnt_d   = '0;
        end else if (!owner_req || (timer_q == '0)) begin
          // Normal completion acks; an owner that dropped its request does not.
          if (owner_req) begin
            ack_d = gnt_q;
          end
          gnt_d    = '0;
          rr_ptr_d = ptr_adv;
          if (BLANK_CYCLES > 0) begin
            state_d = BLANK;
            timer_d = BLANK_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end

      BLANK: begin
        if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Digit mapping: d1..d4 show the value nibbles LSB first, d6 the owner index,
  // d8 the tag; d5/d7 stay dark as separators. All digits blank outside SHOW.
  always_comb begin
    d1 = BLANK_DIGIT;
    d2 = BLANK_DIGIT;
    d3 = BLANK_DIGIT;
    d4 = BLANK_DIGIT;
    d5 = BLANK_DIGIT;
    d6 = BLANK_DIGIT;
    d7 = BLANK_DIGIT;
    d8 = BLANK_DIGIT;
    if (state_q == SHOW) begin
      d1 = mk_digit(1'b1, data_q[3:0], 1'b0);
      d2 = mk_digit(1'b1, data_q[7:4], 1'b0);
      d3 = mk_digit(1'b1, data_q[11:8], 1'b0);
      d4 = mk_digit(1'b1, data_q[15:12], 1'b0);
      d6 = mk_digit(1'b1, {1'b0, idx_q}, 1'b0);
      d8 = mk_digit(1'b1, {1'b0, tag_q}, 1'b0);
    end
  end

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_dm_page_sched.sv
// Directed bench for dm_page_sched with N=3, DWELL_CYCLES=4, BLANK_CYCLES=2.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Ports: drives clock/reset/req/data/tag, observes gnt/ack/busy/d1..d8.
module tb_dm_page_sched;

  localparam int N = 3;

  logic           clock;
  logic           reset;
  logic [N-1:0]   req;
  logic [16*N-1:0] data;
  logic [3*N-1:0] tag;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic           busy;
  logic [5:0]     d1, d2, d3, d4, d5, d6, d7, d8;

  dm_page_sched #(
    .N            (N),
    .DWELL_CYCLES (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .data  (data),
    .tag   (tag),
    .gnt   (gnt),
    .ack   (ack),
    .busy  (busy),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .d4    (d4),
    .d5    (d5),
    .d6    (d6),
    .d7    (d7),
    .d8    (d8)
  );

  typedef struct {
    logic [2:0] req;
    logic [2:0] gnt;
    logic [2:0] ack;
    logic       busy;
    logic       show;
    int         idx;
  } vec_t;

  vec_t        vt [13];
  logic [15:0] dtab [3];
  logic [2:0]  ttab [3];
  int          n_checks;
  int          n_fail;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected {d8..d1} for a page of requester idx, built from the bench's own tables.
  function automatic logic [47:0] exp_digits(input logic show, input int idx);
    logic [47:0] r;
    logic [15:0] v;
    r = '0;
    if (show) begin
      v = dtab[idx];
      for (int k = 0; k < 4; k++) begin
        r[6*k +: 6] = {1'b1, v[4*k +: 4], 1'b0};
      end
      r[30 +: 6] = {1'b1, 1'b0, 3'(idx), 1'b0};
      r[42 +: 6] = {1'b1, 1'b0, ttab[idx], 1'b0};
    end
    return r;
  endfunction

  task automatic check_outs(input string name, input logic [2:0] g, input logic [2:0] a,
                            input logic b, input logic show, input int idx);
    check({name, ".gnt"}, {45'd0, gnt}, {45'd0, g});
    check({name, ".ack"}, {45'd0, ack}, {45'd0, a});
    check({name, ".busy"}, {47'd0, busy}, {47'd0, b});
    check({name, ".digits"}, {d8, d7, d6, d5, d4, d3, d2, d1}, exp_digits(show, idx));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    dtab[0] = 16'h1234; dtab[1] = 16'hBEEF; dtab[2] = 16'hA5C0;
    ttab[0] = 3'd3;     ttab[1] = 3'd5;     ttab[2] = 3'd7;

    reset = 1'b0;
    req   = '0;
    data  = {dtab[2], dtab[1], dtab[0]};
    tag   = {ttab[2], ttab[1], ttab[0]};

    // Requester 1 page: 4 show cycles, ack with gap start, 2 blank cycles, idle.
    vt[0]  = '{3'b010, 3'b010, 3'b000, 1'b1, 1'b1, 1};
    vt[1]  = '{3'b010, 3'b010, 3'b000, 1'b1, 1'b1, 1};
    vt[2]  = '{3'b010, 3'b010, 3'b000, 1'b1, 1'b1, 1};
    vt[3]  = '{3'b010, 3'b010, 3'b000, 1'b1, 1'b1, 1};
    vt[4]  = '{3'b010, 3'b000, 3'b010, 1'b1, 1'b0, 0};
    vt[5]  = '{3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 0};
    vt[6]  = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 0};
    vt[7]  = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 0};
    // Requester 2 drops its request after 2 show cycles: no ack, gap, idle.
    vt[8]  = '{3'b100, 3'b100, 3'b000, 1'b1, 1'b1, 2};
    vt[9]  = '{3'b100, 3'b100, 3'b000, 1'b1, 1'b1, 2};
    vt[10] = '{3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 0};
    vt[11] = '{3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 0};
    vt[12] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 0};

    #12;
    check_outs("reset", 3'b000, 3'b000, 1'b0, 1'b0, 0);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_outs($sformatf("idle%0d", i), 3'b000, 3'b000, 1'b0, 1'b0, 0);
    end

    for (int i = 0; i < 13; i++) begin
      req = vt[i].req;
      step();
      check_outs($sformatf("vec%0d", i), vt[i].gnt, vt[i].ack, vt[i].busy, vt[i].show, vt[i].idx);
      if (i == 0) begin
        check("beef.d1", {42'd0, d1}, {42'd0, 6'b1_1111_0});
        check("beef.d4", {42'd0, d4}, {42'd0, 6'b1_1011_0});
        check("beef.d6", {42'd0, d6}, {42'd0, 6'b1_0001_0});
        check("beef.d8", {42'd0, d8}, {42'd0, 6'b1_0101_0});
      end
    end

`ifdef DM_PREEMPT_EN
    // Requester 1 showing, requester 0 rises: abort without ack, grant 0 next edge.
    req = 3'b010;
    step();
    check_outs("pre_g1", 3'b010, 3'b000, 1'b1, 1'b1, 1);
    step();
    req = 3'b011;
    step();
    check_outs("pre_abort", 3'b000, 3'b000, 1'b0, 1'b0, 0);
    step();
    check_outs("pre_g0", 3'b001, 3'b000, 1'b1, 1'b1, 0);
    req = 3'b001;
    step();
    step();
    step();
    check_outs("pre_hold0", 3'b001, 3'b000, 1'b1, 1'b1, 0);
    step();
    check_outs("pre_ack0", 3'b000, 3'b001, 1'b1, 1'b0, 0);
    req = 3'b000;
    step();
    step();
    check_outs("pre_drain", 3'b000, 3'b000, 1'b0, 1'b0, 0);
`else
    // All three requesting: 7-edge period (4 show, 2 blank, 1 idle), order 0,1,2,0,1.
    req = 3'b111;
    for (int k = 1; k <= 30; k++) begin
      int p;
      int ix;
      logic [2:0] oh;
      p  = (k - 1) % 7;
      ix = ((k - 1) / 7) % 3;
      oh = 3'(1 << ix);
      step();
      if (p < 4) begin
        check_outs($sformatf("rr%0d", k), oh, 3'b000, 1'b1, 1'b1, ix);
      end else if (p == 4) begin
        check_outs($sformatf("rr%0d", k), 3'b000, oh, 1'b1, 1'b0, 0);
      end else if (p == 5) begin
        check_outs($sformatf("rr%0d", k), 3'b000, 3'b000, 1'b1, 1'b0, 0);
      end else begin
        check_outs($sformatf("rr%0d", k), 3'b000, 3'b000, 1'b0, 1'b0, 0);
      end
    end

    // Reset mid-page of requester 1: outputs blank at once, restart from pointer 0.
    reset = 1'b0;
    #1;
    check_outs("rst_mid", 3'b000, 3'b000, 1'b0, 1'b0, 0);
    step();
    check_outs("rst_hold", 3'b000, 3'b000, 1'b0, 1'b0, 0);
    reset = 1'b1;
    step();
    check_outs("rst_regrant", 3'b001, 3'b000, 1'b1, 1'b1, 0);

    // Input changes during a page must not reach the digits.
    data = {dtab[2], dtab[1], 16'hFFFF};
    tag  = {ttab[2], ttab[1], 3'd0};
    step();
    check_outs("frozen", 3'b001, 3'b000, 1'b1, 1'b1, 0);
    data = {dtab[2], dtab[1], dtab[0]};
    tag  = {ttab[2], ttab[1], ttab[0]};
    step();
    step();
    check_outs("p0_last", 3'b001, 3'b000, 1'b1, 1'b1, 0);
    step();
    check_outs("p0_ack", 3'b000, 3'b001, 1'b1, 1'b0, 0);
    req = 3'b000;
    step();
    step();
    check_outs("drain", 3'b000, 3'b000, 1'b0, 1'b0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
